// File: rtl/fft_output_serializer.sv
`timescale 1ns/1ps
// Captures a 16-point complex FFT frame in one cycle and streams it out one
// sample per valid/ready transfer, in natural or bit-reversed order.
module fft_output_serializer #(
  parameter int WIDTH  = 16,
  parameter int NPOINT = 16,
  parameter bit BITREV = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  output logic             load_ready,
  input  logic [WIDTH-1:0] datain0,  datain1,  datain2,  datain3,
  input  logic [WIDTH-1:0] datain4,  datain5,  datain6,  datain7,
  input  logic [WIDTH-1:0] datain8,  datain9,  datain10, datain11,
  input  logic [WIDTH-1:0] datain12, datain13, datain14, datain15,
  input  logic [WIDTH-1:0] datain16, datain17, datain18, datain19,
  input  logic [WIDTH-1:0] datain20, datain21, datain22, datain23,
  input  logic [WIDTH-1:0] datain24, datain25, datain26, datain27,
  input  logic [WIDTH-1:0] datain28, datain29, datain30, datain31,
  output logic [WIDTH-1:0] dout_re,
  output logic [WIDTH-1:0] dout_im,
  output logic [3:0]       dout_idx,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state, state_nxt;
  logic [3:0]       k, k_nxt, p_nxt;
  logic             capture, xfer, last;
  logic [WIDTH-1:0] din_re [NPOINT];
  logic [WIDTH-1:0] din_im [NPOINT];
  logic [WIDTH-1:0] buf_re [NPOINT];
  logic [WIDTH-1:0] buf_im [NPOINT];

  assign din_re[0]  = datain0;   assign din_re[1]  = datain1;
  assign din_re[2]  = datain2;   assign din_re[3]  = datain3;
  assign din_re[4]  = datain4;   assign din_re[5]  = datain5;
  assign din_re[6]  = datain6;   assign din_re[7]  = datain7;
  assign din_re[8]  = datain8;   assign din_re[9]  = datain9;
  assign din_re[10] = datain10;  assign din_re[11] = datain11;
  assign din_re[12] = datain12;  assign din_re[13] = datain13;
  assign din_re[14] = datain14;  assign din_re[15] = datain15;
  assign din_im[0]  = datain16;  assign din_im[1]  = datain17;
  assign din_im[2]  = datain18;  assign din_im[3]  = datain19;
  assign din_im[4]  = datain20;  assign din_im[5]  = datain21;
  assign din_im[6]  = datain22;  assign din_im[7]  = datain23;
  assign din_im[8]  = datain24;  assign din_im[9]  = datain25;
  assign din_im[10] = datain26;  assign din_im[11] = datain27;
  assign din_im[12] = datain28;  assign din_im[13] = datain29;
  assign din_im[14] = datain30;  assign din_im[15] = datain31;

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // Position of the sample presented after the next transfer
  assign k_nxt = k + 4'd1;
  assign p_nxt = BITREV ? bitrev4(k_nxt) : k_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    dout_valid = 1'b0;
    capture    = 1'b0;
    xfer       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load) begin
          capture   = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        busy       = 1'b1;
        dout_valid = 1'b1;
        if (dout_ready) begin
          xfer = 1'b1;
          if (k == 4'd15) begin
            last      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Position 0 maps to itself in both orders, so the first sample comes straight from the inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k        <= '0;
      dout_re  <= '0;
      dout_im  <= '0;
      dout_idx <= '0;
      done     <= 1'b0;
      for (int i = 0; i < NPOINT; i++) begin
        buf_re[i] <= '0;
        buf_im[i] <= '0;
      end
    end else begin
      done <= last;
      if (capture) begin
        for (int i = 0; i < NPOINT; i++) begin
          buf_re[i] <= din_re[i];
          buf_im[i] <= din_im[i];
        end
        k        <= '0;
        dout_re  <= din_re[0];
        dout_im  <= din_im[0];
        dout_idx <= '0;
      end else if (last) begin
        k        <= '0;
        dout_re  <= '0;
        dout_im  <= '0;
        dout_idx <= '0;
      end else if (xfer) begin
        k        <= k_nxt;
        dout_re  <= buf_re[p_nxt];
        dout_im  <= buf_im[p_nxt];
        dout_idx <= p_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fft_output_serializer.sv
`timescale 1ns/1ps
// Bench for fft_output_serializer: natural and bit-reversed instances share
// stimulus and are checked against a queue-based frame model.
module tb_fft_output_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic        dout_ready = 1'b0;
  logic [15:0] din [32];

  logic [15:0] nat_re, nat_im, rev_re, rev_im;
  logic [3:0]  nat_idx, rev_idx;
  logic        nat_valid, nat_busy, nat_done, nat_lr;
  logic        rev_valid, rev_busy, rev_done, rev_lr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fft_output_serializer #(.WIDTH(16), .NPOINT(16), .BITREV(1'b0)) u_nat (
    .clk(clk), .reset(reset), .load(load), .load_ready(nat_lr),
    .datain0(din[0]),   .datain1(din[1]),   .datain2(din[2]),   .datain3(din[3]),
    .datain4(din[4]),   .datain5(din[5]),   .datain6(din[6]),   .datain7(din[7]),
    .datain8(din[8]),   .datain9(din[9]),   .datain10(din[10]), .datain11(din[11]),
    .datain12(din[12]), .datain13(din[13]), .datain14(din[14]), .datain15(din[15]),
    .datain16(din[16]), .datain17(din[17]), .datain18(din[18]), .datain19(din[19]),
    .datain20(din[20]), .datain21(din[21]), .datain22(din[22]), .datain23(din[23]),
    .datain24(din[24]), .datain25(din[25]), .datain26(din[26]), .datain27(din[27]),
    .datain28(din[28]), .datain29(din[29]), .datain30(din[30]), .datain31(din[31]),
    .dout_re(nat_re), .dout_im(nat_im), .dout_idx(nat_idx), .dout_valid(nat_valid),
    .dout_ready(dout_ready), .busy(nat_busy), .done(nat_done)
  );

  fft_output_serializer #(.WIDTH(16), .NPOINT(16), .BITREV(1'b1)) u_rev (
    .clk(clk), .reset(reset), .load(load), .load_ready(rev_lr),
    .datain0(din[0]),   .datain1(din[1]),   .datain2(din[2]),   .datain3(din[3]),
    .datain4(din[4]),   .datain5(din[5]),   .datain6(din[6]),   .datain7(din[7]),
    .datain8(din[8]),   .datain9(din[9]),   .datain10(din[10]), .datain11(din[11]),
    .datain12(din[12]), .datain13(din[13]), .datain14(din[14]), .datain15(din[15]),
    .datain16(din[16]), .datain17(din[17]), .datain18(din[18]), .datain19(din[19]),
    .datain20(din[20]), .datain21(din[21]), .datain22(din[22]), .datain23(din[23]),
    .datain24(din[24]), .datain25(din[25]), .datain26(din[26]), .datain27(din[27]),
    .datain28(din[28]), .datain29(din[29]), .datain30(din[30]), .datain31(din[31]),
    .dout_re(rev_re), .dout_im(rev_im), .dout_idx(rev_idx), .dout_valid(rev_valid),
    .dout_ready(dout_ready), .busy(rev_busy), .done(rev_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame becomes a queue of pending samples in output order
  typedef struct {logic [3:0] idx; logic [15:0] re; logic [15:0] im;} samp_t;
  samp_t q_nat[$];
  samp_t q_rev[$];
  bit    exp_done = 1'b0;

  function automatic int brev(input int n);
    int r = 0;
    for (int b = 0; b < 4; b++)
      if (((n >> b) & 1) == 1) r += 1 << (3 - b);
    return r;
  endfunction

  function automatic samp_t mk(input int pos);
    samp_t s;
    s.idx = 4'(pos);
    s.re  = din[pos];
    s.im  = din[16 + pos];
    return s;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_nat.delete();
      q_rev.delete();
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (q_nat.size() == 0) begin
        if (load)
          for (int n = 0; n < 16; n++) begin
            q_nat.push_back(mk(n));
            q_rev.push_back(mk(brev(n)));
          end
      end else if (dout_ready) begin
        void'(q_nat.pop_front());
        void'(q_rev.pop_front());
        if (q_nat.size() == 0) exp_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("nat_valid", 32'(nat_valid), 32'(q_nat.size() != 0));
      check("nat_busy",  32'(nat_busy),  32'(q_nat.size() != 0));
      check("nat_load_ready", 32'(nat_lr), 32'(q_nat.size() == 0));
      check("nat_done",  32'(nat_done),  32'(exp_done));
      check("rev_valid", 32'(rev_valid), 32'(q_rev.size() != 0));
      check("rev_load_ready", 32'(rev_lr), 32'(q_rev.size() == 0));
      check("rev_done",  32'(rev_done),  32'(exp_done));
      if (q_nat.size() != 0) begin
        check("nat_idx", 32'(nat_idx), 32'(q_nat[0].idx));
        check("nat_re",  32'(nat_re),  32'(q_nat[0].re));
        check("nat_im",  32'(nat_im),  32'(q_nat[0].im));
        check("rev_idx", 32'(rev_idx), 32'(q_rev[0].idx));
        check("rev_re",  32'(rev_re),  32'(q_rev[0].re));
        check("rev_im",  32'(rev_im),  32'(q_rev[0].im));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp_frame();
    for (int i = 0; i < 16; i++) begin
      din[i]      = 16'(i);
      din[16 + i] = 16'(16'h100 + i);
    end
  endtask

  task automatic set_rand_frame();
    for (int i = 0; i < 32; i++) din[i] = 16'($urandom);
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    for (int c = 0; c < limit && nat_busy; c++) tick();
    tick();
    check(name, 32'(nat_busy), 32'(0));
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_nat_re"},    32'(nat_re),    32'(0));
    check({name, "_nat_im"},    32'(nat_im),    32'(0));
    check({name, "_nat_idx"},   32'(nat_idx),   32'(0));
    check({name, "_nat_valid"}, 32'(nat_valid), 32'(0));
    check({name, "_nat_busy"},  32'(nat_busy),  32'(0));
    check({name, "_nat_done"},  32'(nat_done),  32'(0));
    check({name, "_nat_lr"},    32'(nat_lr),    32'(1));
    check({name, "_rev_re"},    32'(rev_re),    32'(0));
    check({name, "_rev_idx"},   32'(rev_idx),   32'(0));
    check({name, "_rev_done"},  32'(rev_done),  32'(0));
  endtask

  typedef struct {int k; logic [3:0] nat_idx; logic [3:0] rev_idx;} vec_t;
  vec_t tab[16];
  int   rev_seq[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  initial begin
    int xfers, dones;
    for (int i = 0; i < 16; i++) tab[i] = '{i, 4'(i), 4'(rev_seq[i])};
    for (int i = 0; i < 32; i++) din[i] = 16'h0;

    // Reset state
    #12;
    check_zero_outputs("reset");
    tick();
    reset = 1'b1;
    tick();

    // Ramp frame, ready held high, table-driven sample order
    set_ramp_frame();
    dout_ready = 1'b1;
    pulse_load();
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      check("tab_nat_idx", 32'(nat_idx), 32'(tab[n].nat_idx));
      check("tab_nat_re",  32'(nat_re),  32'(tab[n].nat_idx));
      check("tab_nat_im",  32'(nat_im),  32'(16'h100) + 32'(tab[n].nat_idx));
      check("tab_rev_idx", 32'(rev_idx), 32'(tab[n].rev_idx));
      check("tab_rev_re",  32'(rev_re),  32'(tab[n].rev_idx));
      check("tab_rev_im",  32'(rev_im),  32'(16'h100) + 32'(tab[n].rev_idx));
    end
    @(negedge clk);
    check("ramp_done", 32'(nat_done), 32'(1));
    check("ramp_load_ready", 32'(nat_lr), 32'(1));
    tick();

    // Ready toggling 1,0,0: holds, 16 transfers, one done pulse
    set_ramp_frame();
    pulse_load();
    xfers = 0;
    dones = 0;
    for (int c = 0; c < 70; c++) begin
      dout_ready = (c % 3 == 0);
      @(negedge clk);
      if (nat_valid && dout_ready) xfers++;
      if (nat_done) dones++;
      tick();
    end
    check("toggle_xfers", 32'(xfers), 32'(16));
    check("toggle_done_count", 32'(dones), 32'(1));

    // Load pulse during stream is ignored; a held load is taken at load_ready
    dout_ready = 1'b1;
    set_ramp_frame();
    pulse_load();
    tick();
    tick();
    din[0] = 16'h7FFF;
    pulse_load();
    load = 1'b1;
    for (int c = 0; c < 40 && !nat_lr; c++) tick();
    tick();
    load = 1'b0;
    @(negedge clk);
    check("held_load_re", 32'(nat_re), 32'(16'h7FFF));
    check("held_load_valid", 32'(nat_valid), 32'(1));
    wait_idle("held_load_finish", 40);

    // Reset mid-stream at idx 6
    set_ramp_frame();
    pulse_load();
    for (int c = 0; c < 30 && !(nat_valid && nat_idx == 4'd6); c++) tick();
    check("reached_idx6", 32'(nat_idx), 32'(6));
    #2;
    reset = 1'b0;
    #1;
    check_zero_outputs("midreset");
    for (int c = 0; c < 3; c++) begin
      tick();
      check("midreset_done_low", 32'(nat_done), 32'(0));
    end
    reset = 1'b1;
    tick();
    check("post_reset_done", 32'(nat_done), 32'(0));
    din[0] = 16'h8000;
    pulse_load();
    @(negedge clk);
    check("neg_full_nat_re", 32'(nat_re), 32'(16'h8000));
    check("neg_full_rev_re", 32'(rev_re), 32'(16'h8000));
    check("neg_full_idx", 32'(nat_idx), 32'(0));
    wait_idle("neg_full_finish", 40);

    // Back-to-back: second load in the done cycle
    set_ramp_frame();
    pulse_load();
    for (int c = 0; c < 40 && !nat_done; c++) tick();
    check("b2b_done_seen", 32'(nat_done), 32'(1));
    set_rand_frame();
    pulse_load();
    @(negedge clk);
    check("b2b_idx", 32'(nat_idx), 32'(0));
    check("b2b_re", 32'(nat_re), 32'(din[0]));
    check("b2b_im", 32'(nat_im), 32'(din[16]));
    check("b2b_valid", 32'(nat_valid), 32'(1));
    wait_idle("b2b_finish", 40);

    // Random data, ready and load against the model
    for (int c = 0; c < 600; c++) begin
      set_rand_frame();
      dout_ready = ($urandom_range(0, 3) != 0);
      load       = ($urandom_range(0, 3) == 0);
      tick();
    end
    load = 1'b0;
    dout_ready = 1'b1;
    wait_idle("random_finish", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
